// File: rtl/map_render_sequencer_if.sv
// Signal bundle between the map render sequencer (master) and its surroundings:
// map RAM, square/circle drawers and the VGA adapter (slave side).
interface map_render_sequencer_if;
    logic       start;
    logic       busy;
    logic       frame_done;
    logic [4:0] map_x;
    logic [4:0] map_y;
    logic       map_rd;
    logic [3:0] map_type;
    logic       sq_en;
    logic       sq_done;
    logic [7:0] sq_vga_x;
    logic [6:0] sq_vga_y;
    logic       sq_vga_plot;
    logic       dot_en;
    logic       dot_done;
    logic [7:0] dot_vga_x;
    logic [6:0] dot_vga_y;
    logic       dot_vga_plot;
    logic [7:0] left_x;
    logic [6:0] top_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic       vga_plot;
    logic [2:0] vga_color;

    modport master (
        input  start, map_type,
        input  sq_done, sq_vga_x, sq_vga_y, sq_vga_plot,
        input  dot_done, dot_vga_x, dot_vga_y, dot_vga_plot,
        output busy, frame_done, map_x, map_y, map_rd,
        output sq_en, dot_en, left_x, top_y,
        output vga_x, vga_y, vga_plot, vga_color
    );

    modport slave (
        output start, map_type,
        output sq_done, sq_vga_x, sq_vga_y, sq_vga_plot,
        output dot_done, dot_vga_x, dot_vga_y, dot_vga_plot,
        input  busy, frame_done, map_x, map_y, map_rd,
        input  sq_en, dot_en, left_x, top_y,
        input  vga_x, vga_y, vga_plot, vga_color
    );
endinterface

// File: rtl/map_render_sequencer.sv
// Walks the maze map once per start pulse, launches the square or circle drawer
// for every tile and multiplexes the active drawer's pixels onto the VGA port.
module map_render_sequencer #(
    parameter int GRID_W  = 21,
    parameter int GRID_H  = 21,
    parameter int TILE_PX = 5
) (
    input logic                    clock_50,
    input logic                    reset,
    map_render_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, NEXT, FINISH} state_t;

    localparam logic [4:0] LAST_X = 5'(GRID_W - 1);
    localparam logic [4:0] LAST_Y = 5'(GRID_H - 1);
    localparam logic [7:0] STEP_X = 8'(TILE_PX);
    localparam logic [6:0] STEP_Y = 7'(TILE_PX);

    state_t     state;
    state_t     state_next;
    logic [3:0] tile_type;
    logic [4:0] map_x;
    logic [4:0] map_y;
    logic [7:0] left_x;
    logic [6:0] top_y;
    logic [2:0] vga_color;
    logic       sel_sq;
    logic       sel_dot;
    logic       last_tile;

    function automatic logic [2:0] tile_colour(input logic [3:0] t);
        case (t)
            4'd1:    tile_colour = 3'b001;
            4'd2:    tile_colour = 3'b111;
            default: tile_colour = 3'b000;
        endcase
    endfunction

    assign sel_sq    = (tile_type == 4'd0) || (tile_type == 4'd1);
    assign sel_dot   = (tile_type == 4'd2);
    assign last_tile = (map_x == LAST_X) && (map_y == LAST_Y);

    assign bus.map_x     = map_x;
    assign bus.map_y     = map_y;
    assign bus.left_x    = left_x;
    assign bus.top_y     = top_y;
    assign bus.vga_color = vga_color;

    // Origins are stepped by TILE_PX alongside the tile indices, which equals the truncated product.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state     <= IDLE;
            tile_type <= 4'd0;
            map_x     <= 5'd0;
            map_y     <= 5'd0;
            left_x    <= 8'd0;
            top_y     <= 7'd0;
            vga_color <= 3'b000;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        map_x  <= 5'd0;
                        map_y  <= 5'd0;
                        left_x <= 8'd0;
                        top_y  <= 7'd0;
                    end
                end
                WAIT: begin
                    tile_type <= bus.map_type;
                    vga_color <= tile_colour(bus.map_type);
                end
                NEXT: begin
                    if (!last_tile) begin
                        if (map_x == LAST_X) begin
                            map_x  <= 5'd0;
                            left_x <= 8'd0;
                            map_y  <= map_y + 5'd1;
                            top_y  <= top_y + STEP_Y;
                        end else begin
                            map_x  <= map_x + 5'd1;
                            left_x <= left_x + STEP_X;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state plus decoded outputs; the pixel mux is transparent only while a drawer runs.
    always_comb begin
        state_next     = state;
        bus.busy       = (state != IDLE);
        bus.frame_done = 1'b0;
        bus.map_rd     = 1'b0;
        bus.sq_en      = 1'b0;
        bus.dot_en     = 1'b0;
        bus.vga_x      = 8'd0;
        bus.vga_y      = 7'd0;
        bus.vga_plot   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = FETCH;
            end
            FETCH: begin
                bus.map_rd = 1'b1;
                state_next = WAIT;
            end
            WAIT: state_next = DRAW;
            DRAW: begin
                if (sel_sq) begin
                    bus.sq_en    = 1'b1;
                    bus.vga_x    = bus.sq_vga_x;
                    bus.vga_y    = bus.sq_vga_y;
                    bus.vga_plot = bus.sq_vga_plot;
                    if (bus.sq_done) state_next = NEXT;
                end else if (sel_dot) begin
                    bus.dot_en   = 1'b1;
                    bus.vga_x    = bus.dot_vga_x;
                    bus.vga_y    = bus.dot_vga_y;
                    bus.vga_plot = bus.dot_vga_plot;
                    if (bus.dot_done) state_next = NEXT;
                end else begin
                    state_next = NEXT;
                end
            end
            NEXT: state_next = last_tile ? FINISH : FETCH;
            FINISH: begin
                bus.frame_done = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_map_render_sequencer.sv
// Bench for map_render_sequencer: behavioural map RAM and drawer models, a per-cycle
// monitor, a table of whole-frame vectors and hand sequences for stall and reset cases.
module tb_map_render_sequencer;
    logic clock_50 = 1'b0;
    logic reset;

    always #10 clock_50 = ~clock_50;

    map_render_sequencer_if bus();

    map_render_sequencer #(.GRID_W(21), .GRID_H(21), .TILE_PX(5)) dut (
        .clock_50(clock_50),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int fill;
        int sp_x;
        int sp_y;
        int sp_type;
        int sq_lat;
        int dot_lat;
        bit inject;
        int exp_sq;
        int exp_dot;
        int exp_busy;
        bit chk_geo;
        int exp_lx;
        int exp_ty;
        int exp_col;
    } vec_t;

    logic [3:0] map_mem [0:20][0:20];
    int sq_lat, dot_lat, lat_x, lat_y, lat_val;
    bit inject;
    int checks = 0;
    int failures = 0;

    // Per-frame monitor results, cleared when busy rises.
    int sq_win, dot_win, fd_cnt, rd_cnt, busy_cyc, viol, cur_len, spec_len;
    int first_rd_x, first_rd_y, exp_x, exp_y, sq_cnt, dot_cnt;
    logic [7:0] dot_lx;
    logic [6:0] dot_ty;
    logic [2:0] dot_col;
    bit prev_sq = 0, prev_dot = 0, prev_rd = 0, prev_busy = 0, win_at_sp = 0;

    function automatic logic [2:0] exp_colour(input logic [3:0] t);
        if (t == 4'd1) return 3'b001;
        if (t == 4'd2) return 3'b111;
        return 3'b000;
    endfunction

    function automatic int tile_lat(input int base);
        if (int'(bus.map_x) == lat_x && int'(bus.map_y) == lat_y) return lat_val;
        return base;
    endfunction

    always @(negedge clock_50) begin
        int cx, cy;
        logic [3:0] t;
        cx = int'(bus.map_x);
        cy = int'(bus.map_y);
        t  = (cx < 21 && cy < 21) ? map_mem[cy][cx] : 4'hF;
        if (bus.busy && !prev_busy) begin
            sq_win = 0; dot_win = 0; fd_cnt = 0; rd_cnt = 0; busy_cyc = 0; viol = 0;
            spec_len = -1; exp_x = 0; exp_y = 0; first_rd_x = cx; first_rd_y = cy;
        end
        if (bus.sq_en && bus.dot_en) viol++;
        if (bus.sq_en) begin
            if (bus.vga_x !== bus.sq_vga_x || bus.vga_y !== bus.sq_vga_y || bus.vga_plot !== bus.sq_vga_plot) viol++;
            if (t > 4'd1 || bus.vga_color !== exp_colour(t)) viol++;
        end else if (bus.dot_en) begin
            if (bus.vga_x !== bus.dot_vga_x || bus.vga_y !== bus.dot_vga_y || bus.vga_plot !== bus.dot_vga_plot) viol++;
            if (t != 4'd2 || bus.vga_color !== 3'b111) viol++;
        end else if (bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0 || bus.vga_plot !== 1'b0) begin
            viol++;
        end
        if (bus.busy) begin
            busy_cyc++;
            if (bus.left_x !== 8'(cx * 5) || bus.top_y !== 7'(cy * 5)) viol++;
        end
        if (bus.map_rd) begin
            if (prev_rd || cx != exp_x || cy != exp_y) viol++;
            rd_cnt++;
            exp_x++;
            if (exp_x == 21) begin exp_x = 0; exp_y++; end
        end
        if (bus.frame_done) begin
            fd_cnt++;
            if (cx != 20 || cy != 20) viol++;
        end
        if ((bus.sq_en && !prev_sq) || (bus.dot_en && !prev_dot)) begin
            cur_len = 0;
            win_at_sp = (cx == lat_x && cy == lat_y);
        end
        if (bus.sq_en && !prev_sq) sq_win++;
        if (bus.dot_en && !prev_dot) begin
            dot_win++;
            dot_lx = bus.left_x; dot_ty = bus.top_y; dot_col = bus.vga_color;
        end
        if (bus.sq_en || bus.dot_en) cur_len++;
        else if ((prev_sq || prev_dot) && win_at_sp) spec_len = cur_len;
        prev_sq = bus.sq_en; prev_dot = bus.dot_en; prev_rd = bus.map_rd; prev_busy = bus.busy;
        // drive map RAM and drawer responses for the coming cycle
        if (bus.map_rd) bus.map_type = t;
        if (bus.sq_en) begin
            sq_cnt++;
            bus.sq_done = (sq_cnt >= tile_lat(sq_lat));
            bus.sq_vga_x = bus.left_x + 8'(sq_cnt);
            bus.sq_vga_y = bus.top_y + 7'(sq_cnt % 5);
            bus.sq_vga_plot = sq_cnt[0];
        end else begin
            sq_cnt = 0;
            bus.sq_done = inject && bus.dot_en;
            bus.sq_vga_x = 8'hA5; bus.sq_vga_y = 7'h5A; bus.sq_vga_plot = 1'b1;
        end
        if (bus.dot_en) begin
            dot_cnt++;
            bus.dot_done = (dot_cnt >= tile_lat(dot_lat));
            bus.dot_vga_x = bus.left_x + 8'(dot_cnt + 1);
            bus.dot_vga_y = bus.top_y + 7'(dot_cnt);
            bus.dot_vga_plot = ~dot_cnt[0];
        end else begin
            dot_cnt = 0;
            bus.dot_done = inject && bus.sq_en;
            bus.dot_vga_x = 8'h3C; bus.dot_vga_y = 7'h63; bus.dot_vga_plot = 1'b1;
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, int'(bus.busy), 0);
        chk({pfx, "_frame_done"}, int'(bus.frame_done), 0);
        chk({pfx, "_map_rd"}, int'(bus.map_rd), 0);
        chk({pfx, "_sq_en"}, int'(bus.sq_en), 0);
        chk({pfx, "_dot_en"}, int'(bus.dot_en), 0);
        chk({pfx, "_vga_plot"}, int'(bus.vga_plot), 0);
        chk({pfx, "_map_x"}, int'(bus.map_x), 0);
        chk({pfx, "_map_y"}, int'(bus.map_y), 0);
        chk({pfx, "_left_x"}, int'(bus.left_x), 0);
        chk({pfx, "_top_y"}, int'(bus.top_y), 0);
        chk({pfx, "_vga_x"}, int'(bus.vga_x), 0);
        chk({pfx, "_vga_y"}, int'(bus.vga_y), 0);
        chk({pfx, "_vga_color"}, int'(bus.vga_color), 0);
    endtask

    task automatic fill_map(input int fill, input int sx, input int sy, input int st);
        for (int y = 0; y < 21; y++)
            for (int x = 0; x < 21; x++)
                map_mem[y][x] = 4'(fill);
        map_mem[sy][sx] = 4'(st);
    endtask

    task automatic run_frame(input string name, input bit pester);
        bit ok;
        @(negedge clock_50) bus.start = 1'b1;
        @(negedge clock_50) bus.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock_50);
            bus.start = pester && (i == 30 || i == 400);
            if (!bus.busy) begin ok = 1'b1; break; end
        end
        bus.start = 1'b0;
        repeat (20) @(negedge clock_50);
        chk({name, "_frame_completes"}, int'(ok), 1);
    endtask

    vec_t vecs [6];

    initial begin
        bit found;
        vecs[0] = '{1, 0, 0, 1, 1, 1, 1'b0, 441, 0, 1765, 1'b0, 0, 0, 0};
        vecs[1] = '{1, 3, 4, 2, 1, 3, 1'b0, 440, 1, 1767, 1'b1, 15, 20, 7};
        vecs[2] = '{0, 0, 0, 9, 1, 1, 1'b0, 440, 0, 1765, 1'b0, 0, 0, 0};
        vecs[3] = '{1, 0, 0, 1, 3, 1, 1'b1, 441, 0, 2647, 1'b0, 0, 0, 0};
        vecs[4] = '{2, 0, 0, 2, 1, 2, 1'b1, 0, 441, 2206, 1'b0, 0, 0, 0};
        vecs[5] = '{1, 20, 20, 15, 2, 1, 1'b0, 440, 0, 2205, 1'b0, 0, 0, 0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.map_type = 4'd0;
        sq_lat = 1; dot_lat = 1; lat_x = 31; lat_y = 31; lat_val = 1; inject = 1'b0;
        fill_map(1, 0, 0, 1);
        repeat (4) @(negedge clock_50);
        chk_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock_50);

        for (int i = 0; i < 6; i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            fill_map(vecs[i].fill, vecs[i].sp_x, vecs[i].sp_y, vecs[i].sp_type);
            sq_lat = vecs[i].sq_lat;
            dot_lat = vecs[i].dot_lat;
            inject = vecs[i].inject;
            run_frame(n, 1'b0);
            chk({n, "_sq_windows"}, sq_win, vecs[i].exp_sq);
            chk({n, "_dot_windows"}, dot_win, vecs[i].exp_dot);
            chk({n, "_frame_done_count"}, fd_cnt, 1);
            chk({n, "_map_reads"}, rd_cnt, 441);
            chk({n, "_busy_cycles"}, busy_cyc, vecs[i].exp_busy);
            chk({n, "_monitor_violations"}, viol, 0);
            chk({n, "_busy_after"}, int'(bus.busy), 0);
            if (vecs[i].chk_geo) begin
                chk({n, "_dot_left_x"}, int'(dot_lx), vecs[i].exp_lx);
                chk({n, "_dot_top_y"}, int'(dot_ty), vecs[i].exp_ty);
                chk({n, "_dot_colour"}, int'(dot_col), vecs[i].exp_col);
            end
        end
        inject = 1'b0; sq_lat = 1; dot_lat = 1;

        // square drawer stalls 50 cycles on tile (5,0) while start is re-pulsed mid-frame
        fill_map(1, 0, 0, 1);
        lat_x = 5; lat_y = 0; lat_val = 50;
        run_frame("stall", 1'b1);
        chk("stall_sq_en_len", spec_len, 50);
        chk("stall_frame_done_count", fd_cnt, 1);
        chk("stall_busy_cycles", busy_cyc, 1814);
        chk("stall_sq_windows", sq_win, 441);
        chk("stall_monitor_violations", viol, 0);
        chk("stall_busy_after", int'(bus.busy), 0);

        // reset while tile (7,2) is drawing, then a fresh frame
        lat_x = 7; lat_y = 2; lat_val = 100000;
        @(negedge clock_50) bus.start = 1'b1;
        @(negedge clock_50) bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock_50);
            if (bus.sq_en && bus.map_x == 5'd7 && bus.map_y == 5'd2) begin found = 1'b1; break; end
        end
        chk("reach_tile_7_2", int'(found), 1);
        repeat (3) @(negedge clock_50);
        reset = 1'b1;
        @(negedge clock_50);
        chk_zero("mid_draw_reset");
        reset = 1'b0;
        lat_x = 31; lat_y = 31;
        repeat (5) @(negedge clock_50);
        chk("idle_after_reset_busy", int'(bus.busy), 0);
        run_frame("restart", 1'b0);
        chk("restart_first_x", first_rd_x, 0);
        chk("restart_first_y", first_rd_y, 0);
        chk("restart_sq_windows", sq_win, 441);
        chk("restart_frame_done_count", fd_cnt, 1);
        chk("restart_busy_cycles", busy_cyc, 1765);
        chk("restart_monitor_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
